// File: rtl/uart_echo_tester.sv
// uart_echo_tester: sends a run of 8N1 pattern bytes on tx and checks that the
// device under test echoes each one back on rx.
//
// Each byte gets its own echo window. The tester counts an error for a data
// mismatch, a framing error (stop bit received as 0) or a missing echo. The
// error count saturates at 255.
//
// Ports:
//   clk        sole clock, rising edge
//   n_rst      asynchronous active-low reset
//   start      one-cycle request to begin a run (ignored while busy)
//   num_bytes  bytes to send in the run, sampled on accepted start
//   rx         serial line from the device under test (asynchronous)
//   tx         serial line to the device under test, idles high
//   busy       high from accepted start until done
//   done       one-cycle pulse at run end
//   pass       high iff err_count==0, valid from done until next start
//   err_count  mismatches + framing errors + timeouts in the current run
//
// Build option: define UART_ECHO_TESTER_LFSR_EN to use an 8-bit Fibonacci LFSR
// pattern (x^8+x^6+x^5+x^4+1, seed 8'hA5). Without it the pattern is an
// incrementing counter starting at 8'h00.
module uart_echo_tester #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned TIMEOUT_BITS = 40
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic [7:0] num_bytes,
    input  logic       rx,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count
);

    localparam int unsigned HALF       = CLKS_PER_BIT / 2;
    localparam int unsigned TMO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned CW         = $clog2(CLKS_PER_BIT);
    localparam int unsigned TW         = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] TAIL_LAST = CW'(CLKS_PER_BIT - HALF - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TMO_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_ECHO, CHECK, FINISH} state_t;
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_TAIL} rx_state_t;

    state_t    state, state_next;
    rx_state_t rx_state, rx_next;

    // ---------------- pattern generator ----------------
    logic [7:0] pattern, pat_next, pat_seed;
    always_comb begin
`ifdef UART_ECHO_TESTER_LFSR_EN
        pat_seed = 8'hA5;
        pat_next = {pattern[6:0], pattern[7] ^ pattern[5] ^ pattern[4] ^ pattern[3]};
`else
        pat_seed = 8'h00;
        pat_next = pattern + 8'd1;
`endif
    end

    // ---------------- rx synchronizer + deserializer ----------------
    logic          rx_s1, rx_s2, rx_d;
    logic          rx_fall;
    logic [CW-1:0] rcnt;
    logic [2:0]    ridx;
    logic [7:0]    rx_data;
    logic          rx_ferr, rx_done;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    assign rx_fall = rx_d & ~rx_s2;

    // Completion is reported at the end of the stop bit rather than at its
    // centre, so a loopback echo never finishes before the tester's own stop
    // bit has gone out and the echo window has opened.
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            R_IDLE:  if (rx_fall) rx_next = R_START;
            R_START: if (rcnt == HALF_LAST) rx_next = rx_s2 ? R_IDLE : R_DATA;
            R_DATA:  if (rcnt == BIT_LAST && ridx == 3'd7) rx_next = R_STOP;
            R_STOP:  if (rcnt == BIT_LAST) rx_next = R_TAIL;
            R_TAIL:  if (rcnt == TAIL_LAST) rx_next = R_IDLE;
            default: rx_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_state <= R_IDLE;
            rcnt     <= '0;
            ridx     <= '0;
            rx_data  <= '0;
            rx_ferr  <= 1'b0;
            rx_done  <= 1'b0;
        end else begin
            rx_state <= rx_next;
            rx_done  <= 1'b0;
            if (rx_next != rx_state || (rx_state == R_DATA && rcnt == BIT_LAST))
                rcnt <= '0;
            else if (rx_state != R_IDLE)
                rcnt <= rcnt + 1'b1;
            case (rx_state)
                R_IDLE: ridx <= '0;
                R_DATA: if (rcnt == BIT_LAST) begin
                    rx_data <= {rx_s2, rx_data[7:1]};
                    ridx    <= ridx + 3'd1;
                end
                R_STOP: if (rcnt == BIT_LAST) rx_ferr <= ~rx_s2;
                R_TAIL: if (rx_next == R_IDLE) rx_done <= 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------- main FSM ----------------
    logic          tx_active;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic [8:0]    tx_shift;
    logic [7:0]    remaining;
    logic [TW-1:0] tmo;
    logic          timeout, skip, pass_r;
    logic [7:0]    err_inc;

    assign timeout = (tmo == TMO_LAST);
    assign err_inc = (err_count == 8'hFF) ? err_count : err_count + 8'd1;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (start) state_next = (num_bytes == 8'd0) ? FINISH : SEND;
            SEND:      if (tx_active && tx_bit == 4'd9 && tx_cnt == BIT_LAST) state_next = WAIT_ECHO;
            WAIT_ECHO: if (rx_done || timeout) state_next = CHECK;
            CHECK:     state_next = (remaining == 8'd1) ? FINISH : SEND;
            FINISH:    state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tx        <= 1'b1;
            tx_active <= 1'b0;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_shift  <= '1;
            pattern   <= '0;
            remaining <= '0;
            err_count <= '0;
            skip      <= 1'b0;
            pass_r    <= 1'b0;
            tmo       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (start) begin
                        remaining <= num_bytes;
                        err_count <= '0;
                        pass_r    <= 1'b0;
                        pattern   <= pat_seed;
                    end
                end
                SEND: begin
                    skip <= 1'b0;
                    tmo  <= '0;
                    if (!tx_active) begin
                        tx        <= 1'b0;
                        tx_active <= 1'b1;
                        tx_cnt    <= '0;
                        tx_bit    <= '0;
                        tx_shift  <= {1'b1, pattern};
                    end else if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 4'd9) begin
                            tx_active <= 1'b0;
                        end else begin
                            tx       <= tx_shift[0];
                            tx_shift <= {1'b1, tx_shift[8:1]};
                            tx_bit   <= tx_bit + 4'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                WAIT_ECHO: begin
                    tmo <= tmo + 1'b1;
                    // A byte finishing on the timeout cycle wins.
                    if (timeout && !rx_done) begin
                        skip      <= 1'b1;
                        err_count <= err_inc;
                    end
                end
                CHECK: begin
                    if (!skip && (rx_data != pattern || rx_ferr))
                        err_count <= err_inc;
                    pattern   <= pat_next;
                    remaining <= remaining - 8'd1;
                end
                FINISH: pass_r <= (err_count == 8'd0);
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == FINISH);
    assign pass = pass_r | (done && err_count == 8'd0);

endmodule

// File: tb/tb_uart_echo_tester.sv
module tb_uart_echo_tester;

    localparam int C  = 4;
    localparam int TB = 40;

    logic       clk = 1'b0;
    logic       n_rst, start = 1'b0, rx_drv = 1'b1, loop_en = 1'b1;
    logic [7:0] num_bytes = 8'd0;
    logic       rx, tx, busy, done, pass;
    logic [7:0] err_count;

    assign rx = loop_en ? tx : rx_drv;

    uart_echo_tester #(.CLKS_PER_BIT(C), .TIMEOUT_BITS(TB)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .num_bytes(num_bytes), .rx(rx),
        .tx(tx), .busy(busy), .done(done), .pass(pass), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    typedef enum int {A_OK, A_XOR, A_BADSTOP, A_DROP} act_t;
    act_t       acts [256];
    logic [7:0] xmask[256];

    logic [7:0] q[$];
    longint     starts[$];
    int         mon_idx = 0;

    // Expected k-th byte of a run, from the pattern definition.
    function automatic logic [7:0] exp_byte(input int k);
        logic [7:0] s;
`ifdef UART_ECHO_TESTER_LFSR_EN
        s = 8'hA5;
        for (int i = 0; i < k; i++) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
`else
        s = 8'(k % 256);
`endif
        return s;
    endfunction

    task automatic send_echo(input logic [7:0] b, input logic stop_bit);
        repeat ($urandom_range(0, 8)) @(posedge clk);
        rx_drv = 1'b0;
        repeat (C) @(posedge clk);
        for (int j = 0; j < 8; j++) begin
            rx_drv = b[j];
            repeat (C) @(posedge clk);
        end
        rx_drv = stop_bit;
        repeat (C) @(posedge clk);
        rx_drv = 1'b1;
    endtask

    // Line monitor: decodes every tx frame and, in echo mode, answers it.
    initial begin : monitor
        logic [7:0] b;
        act_t       a;
        forever begin
            @(negedge tx);
            starts.push_back(longint'($time));
            repeat (2) @(negedge clk);
            for (int j = 0; j < 8; j++) begin
                repeat (C) @(negedge clk);
                b[j] = tx;
            end
            repeat (C) @(negedge clk);
            check_eq("tx_stop", 32'(tx), 32'd1);
            q.push_back(b);
            if (!loop_en) begin
                a = acts[mon_idx[7:0]];
                case (a)
                    A_OK:      send_echo(b, 1'b1);
                    A_XOR:     send_echo(b ^ xmask[mon_idx[7:0]], 1'b1);
                    A_BADSTOP: send_echo(b, 1'b0);
                    default:   ;
                endcase
                mon_idx++;
            end
        end
    end

    task automatic run(input int n, input bit loop, input bit poke, input bit timing);
        int     exp_err;
        int     cyc;
        longint t_done;
        exp_err = 0;
        if (!loop)
            for (int i = 0; i < n; i++) if (acts[i] != A_OK) exp_err++;
        q.delete();
        starts.delete();
        mon_idx = 0;
        loop_en = loop;
        rx_drv  = 1'b1;
        @(negedge clk);
        start = 1'b1;
        num_bytes = 8'(n);
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_after_start", 32'(busy), 32'd1);
        if (poke) begin
            repeat (15) @(negedge clk);
            start = 1'b1;
            num_bytes = 8'd7;
            @(negedge clk);
            start = 1'b0;
        end
        cyc = 0;
        while (!done && cyc < n * 450 + 100) begin
            @(negedge clk);
            cyc++;
        end
        t_done = longint'($time);
        check_eq("done_seen", 32'(done), 32'd1);
        check_eq("err_count", 32'(err_count), 32'(exp_err));
        check_eq("pass", 32'(pass), 32'(exp_err == 0));
        check_eq("byte_count", 32'(q.size()), 32'(n));
        for (int i = 0; i < q.size() && i < n; i++)
            check_eq($sformatf("tx_byte[%0d]", i), 32'(q[i]), 32'(exp_byte(i)));
        if (timing) begin
            for (int i = 1; i < starts.size(); i++)
                check_eq("timeout_gap", 32'(starts[i] - starts[i-1]), 32'd2020);
            if (starts.size() > 0)
                check_eq("timeout_to_done", 32'(t_done - starts[starts.size()-1]), 32'd2015);
        end
        @(negedge clk);
        check_eq("done_pulse_len", 32'(done), 32'd0);
        check_eq("busy_after_done", 32'(busy), 32'd0);
        check_eq("pass_held", 32'(pass), 32'(exp_err == 0));
        repeat (20) @(negedge clk);
    endtask

    task automatic fill_acts(input act_t a, input logic [7:0] m);
        for (int i = 0; i < 256; i++) begin
            acts[i]  = a;
            xmask[i] = m;
        end
    endtask

    initial begin : main
        int n;
        int r;
        n_rst = 1'b1;
        #2 n_rst = 1'b0;
        #1;
        check_eq("rst_tx", 32'(tx), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_pass", 32'(pass), 32'd0);
        check_eq("rst_err", 32'(err_count), 32'd0);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;

        fill_acts(A_OK, 8'h00);
        run(3, 1'b1, 1'b0, 1'b0);               // plain loopback
        fill_acts(A_XOR, 8'h01);
        run(4, 1'b0, 1'b0, 1'b0);               // every echo corrupted
        fill_acts(A_DROP, 8'h00);
        run(2, 1'b0, 1'b0, 1'b1);               // silent line, timeout timing
        fill_acts(A_OK, 8'h00);
        acts[1] = A_BADSTOP;
        run(3, 1'b0, 1'b0, 1'b0);               // framing error on 2nd echo
        run(0, 1'b1, 1'b0, 1'b0);               // zero-byte run
        run(2, 1'b1, 1'b1, 1'b0);               // start while busy is ignored

        // Reset in the middle of data bit 3 of the first frame.
        loop_en = 1'b1;
        @(negedge clk);
        start = 1'b1;
        num_bytes = 8'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (18) @(negedge clk);
        n_rst = 1'b0;
        #1;
        check_eq("midrst_tx", 32'(tx), 32'd1);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_err", 32'(err_count), 32'd0);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (60) @(negedge clk);
        check_eq("post_rst_tx_idle", 32'(tx), 32'd1);
        run(1, 1'b1, 1'b0, 1'b0);

        for (int k = 0; k < 10; k++) begin
            n = int'($urandom_range(0, 6));
            for (int i = 0; i < 8; i++) begin
                r = int'($urandom_range(0, 9));
                acts[i]  = (r < 6) ? A_OK : (r == 6 || r == 9) ? A_XOR : (r == 7) ? A_BADSTOP : A_DROP;
                xmask[i] = 8'($urandom_range(1, 255));
            end
            run(n, $urandom_range(0, 3) == 0, 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
